// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings and helpers for the on-chip SRAM slave.
//   - HTRANS / HSIZE / HRESP encodings
//   - slave state enum (IDLE, WAIT, ERR1, ERR2)
//   - lane_mask(): byte-lane strobes for a transfer size and address offset
// ---------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    // Byte-lane strobes; lane i covers data bits 8i+7:8i.
    // Sizes above a word only reach here when they are being treated as
    // word transfers, so they map to all four lanes.
    function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                             input logic [1:0] addr);
        logic [3:0] m;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << addr;
            HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
            default:    m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sram_dp_be.sv
// ---------------------------------------------------------------------------
// sram_dp_be
// Simple dual-port, byte-enabled 32-bit word array with a registered read.
// On a read/write collision to the same word the read returns the old data;
// the AHB wrapper provides the coherent view.
//   clk_i    clock
//   re_i     read enable (captures raddr_i word into mem_q)
//   raddr_i  read word index
//   rdata_o  registered read data
//   we_i     write enable
//   waddr_i  write word index
//   be_i     byte-lane write strobes
//   wdata_i  write data
// ---------------------------------------------------------------------------
module sram_dp_be #(
    parameter int MEMWIDTH = 14
) (
    input  logic                clk_i,
    input  logic                re_i,
    input  logic [MEMWIDTH-3:0] raddr_i,
    output logic [31:0]         rdata_o,
    input  logic                we_i,
    input  logic [MEMWIDTH-3:0] waddr_i,
    input  logic [3:0]          be_i,
    input  logic [31:0]         wdata_i
);

    localparam int DEPTH = 2 ** (MEMWIDTH - 2);

    logic [31:0] mem_array [DEPTH];
    logic [31:0] mem_q;

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            mem_q <= mem_array[raddr_i];
        end
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_array[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q;

endmodule

// File: rtl/ahb_sram_ws.sv
// ---------------------------------------------------------------------------
// ahb_sram_ws
// AHB-Lite SRAM slave with configurable size, programmable wait states,
// two-cycle ERROR response for illegal size/alignment, and a read-after-write
// bypass so a read pipelined behind a write to the same word sees new data.
//   HCLK, HRESETn       clock, asynchronous active-low reset
//   HSEL, HREADY        select and bus-ready accept qualifiers
//   HADDR, HTRANS       address (high bits alias), transfer type
//   HWRITE, HSIZE       direction, size (byte/half/word)
//   HWDATA              write data (data phase)
//   HREADYOUT, HRESP    slave ready, OKAY/ERROR response
//   HRDATA              read data
// ---------------------------------------------------------------------------
module ahb_sram_ws
    import ahb_pkg::*;
#(
    parameter int MEMWIDTH      = 14,
    parameter int WAIT_STATES   = 0,
    parameter int ERR_UNALIGNED = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam logic [1:0] WS_LOAD = 2'(WAIT_STATES);

    state_e              state_q;
    logic [1:0]          cnt_q;
    logic                hreadyout_q;
    logic                hresp_q;
    logic                wr_pend_q;
    logic [MEMWIDTH-3:0] wr_idx_q;
    logic [3:0]          wr_mask_q;
    logic                rd_seen_q;
    logic [3:0]          byp_mask_q;
    logic [31:0]         byp_data_q;
    logic [3:0]          byp_mask_d;

    logic                accept;
    logic                bad_align;
    logic                illegal;
    logic                acc_ok;
    logic                rd_en;
    logic                commit;
    logic [1:0]          eff_lo;
    logic [3:0]          lanes;
    logic [MEMWIDTH-3:0] idx;
    logic [31:0]         mem_q;
    logic [31:0]         byp_bits;
    logic                unused_addr;

    assign unused_addr = &{1'b0, HADDR[31:MEMWIDTH]};

    // hreadyout_q gates the accept: a master only sees HREADY high here when
    // this slave is not stalling its own data phase (IDLE or ERR2).
    assign accept    = HSEL & HREADY & HTRANS[1] & hreadyout_q;
    assign bad_align = (HSIZE > HSIZE_WORD)
                     | ((HSIZE == HSIZE_HALF) & HADDR[0])
                     | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));
    assign illegal   = (ERR_UNALIGNED != 0) && bad_align;
    assign acc_ok    = accept & ~illegal;
    assign rd_en     = acc_ok & ~HWRITE;
    // Misfits that are not errored are folded onto the word boundary.
    assign eff_lo    = bad_align ? 2'b00 : HADDR[1:0];
    assign lanes     = lane_mask(HSIZE, eff_lo);
    assign idx       = HADDR[MEMWIDTH-1:2];
    // Write data phase ends on the edge where this slave shows ready.
    assign commit    = wr_pend_q & hreadyout_q;
    assign byp_mask_d = (commit && (wr_idx_q == idx)) ? wr_mask_q : 4'b0000;

    sram_dp_be #(
        .MEMWIDTH (MEMWIDTH)
    ) u_ram (
        .clk_i   (HCLK),
        .re_i    (rd_en),
        .raddr_i (idx),
        .rdata_o (mem_q),
        .we_i    (commit),
        .waddr_i (wr_idx_q),
        .be_i    (wr_mask_q),
        .wdata_i (HWDATA)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            wr_pend_q   <= 1'b0;
            wr_idx_q    <= '0;
            wr_mask_q   <= 4'b0000;
            rd_seen_q   <= 1'b0;
            byp_mask_q  <= 4'b0000;
            byp_data_q  <= 32'd0;
        end else begin
            if (commit) begin
                wr_pend_q <= 1'b0;
            end
            if (acc_ok && HWRITE) begin
                wr_pend_q <= 1'b1;
                wr_idx_q  <= idx;
                wr_mask_q <= lanes;
            end
            if (rd_en) begin
                rd_seen_q  <= 1'b1;
                byp_mask_q <= byp_mask_d;
                byp_data_q <= HWDATA;
            end

            case (state_q)
                ST_IDLE, ST_ERR2: begin
                    if (accept && illegal) begin
                        state_q     <= ST_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end else if (acc_ok && (WS_LOAD != 2'd0)) begin
                        state_q     <= ST_WAIT;
                        cnt_q       <= WS_LOAD;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_OKAY;
                    end else begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                    end else begin
                        state_q     <= ST_WAIT;
                        hreadyout_q <= 1'b0;
                    end
                    hresp_q <= HRESP_OKAY;
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byp_lane
            assign byp_bits[8*gi +: 8] = {8{byp_mask_q[gi]}};
        end
    endgenerate

    always_comb begin
        HRDATA = 32'd0;
        if (!hresp_q && rd_seen_q) begin
            HRDATA = (mem_q & ~byp_bits) | (byp_data_q & byp_bits);
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_sram_ws.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_ws
// Directed bench for ahb_sram_ws. Three instances share the bus signals and
// are selected individually: u0 zero wait, u1 two wait states, u2 three.
// Each instance's HREADY is its own HREADYOUT (single-slave bus).
// ---------------------------------------------------------------------------
module tb_ahb_sram_ws;

    logic        HCLK;
    logic        HRESETn;
    logic [2:0]  hsel;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [2:0]  hro;
    logic [2:0]  hrs;
    logic [31:0] hrd [3];

    int checks = 0;
    int errors = 0;

    ahb_sram_ws #(.MEMWIDTH(14), .WAIT_STATES(0), .ERR_UNALIGNED(1)) u0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HREADY(hro[0]),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADYOUT(hro[0]), .HRESP(hrs[0]), .HRDATA(hrd[0]));

    ahb_sram_ws #(.MEMWIDTH(14), .WAIT_STATES(2), .ERR_UNALIGNED(1)) u1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HREADY(hro[1]),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADYOUT(hro[1]), .HRESP(hrs[1]), .HRDATA(hrd[1]));

    ahb_sram_ws #(.MEMWIDTH(14), .WAIT_STATES(3), .ERR_UNALIGNED(1)) u2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HREADY(hro[2]),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADYOUT(hro[2]), .HRESP(hrs[2]), .HRDATA(hrd[2]));

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic bus_idle();
        hsel   = 3'b000;
        HTRANS = 2'b00;
        HADDR  = 32'd0;
        HWRITE = 1'b0;
        HSIZE  = 3'd2;
    endtask

    task automatic addr_phase(input int k, input logic [31:0] addr,
                              input logic wr, input logic [2:0] size);
        hsel    = 3'b000;
        hsel[k] = 1'b1;
        HTRANS  = 2'b10;
        HADDR   = addr;
        HWRITE  = wr;
        HSIZE   = size;
    endtask

    // Non-pipelined write; returns number of HREADYOUT-low data-phase cycles.
    task automatic do_write(input int k, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] data,
                            output int lows);
        addr_phase(k, addr, 1'b1, size);
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = data;
        lows = 0;
        @(negedge HCLK);
        while (hro[k] !== 1'b1 && lows < 9) begin
            lows++;
            @(negedge HCLK);
        end
        @(posedge HCLK); #1;
        $display("write u%0d addr=%h size=%0d data=%h lows=%0d", k, addr, size, data, lows);
    endtask

    // Non-pipelined read; returns final data, low cycles, and whether HRDATA
    // held one value throughout the data phase.
    task automatic do_read(input int k, input logic [31:0] addr,
                           output logic [31:0] data, output int lows, output bit stable);
        logic [31:0] first;
        addr_phase(k, addr, 1'b0, 3'd2);
        @(posedge HCLK); #1;
        bus_idle();
        lows   = 0;
        stable = 1'b1;
        @(negedge HCLK);
        first = hrd[k];
        while (hro[k] !== 1'b1 && lows < 9) begin
            lows++;
            @(negedge HCLK);
            if (hrd[k] !== first) stable = 1'b0;
        end
        data = hrd[k];
        @(posedge HCLK); #1;
        $display("read  u%0d addr=%h data=%h lows=%0d", k, addr, data, lows);
    endtask

    // Write followed by a read issued in the write's data phase (zero-wait u0).
    task automatic pipe_wr_rd(input logic [31:0] waddr, input logic [2:0] wsize,
                              input logic [31:0] wdata, input logic [31:0] raddr,
                              output logic wr_ready, output logic rd_ready,
                              output logic [31:0] rdata);
        addr_phase(0, waddr, 1'b1, wsize);
        @(posedge HCLK); #1;
        HWDATA = wdata;
        addr_phase(0, raddr, 1'b0, 3'd2);
        @(negedge HCLK);
        wr_ready = hro[0];
        @(posedge HCLK); #1;
        bus_idle();
        @(negedge HCLK);
        rd_ready = hro[0];
        rdata    = hrd[0];
        @(posedge HCLK); #1;
        $display("pipe  u0 wr %h size=%0d data=%h -> rd %h data=%h", waddr, wsize, wdata, raddr, rdata);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (hro[k] !== 1'b1) begin errors++; $display("FAIL reset_hreadyout u%0d got %b exp 1", k, hro[k]); end
            checks++;
            if (hrs[k] !== 1'b0) begin errors++; $display("FAIL reset_hresp u%0d got %b exp 0", k, hrs[k]); end
            checks++;
            if (hrd[k] !== 32'd0) begin errors++; $display("FAIL reset_hrdata u%0d got %h exp 00000000", k, hrd[k]); end
        end
        $display("reset checked on all instances");
    endtask

    task automatic test_zero_wait();
        int lows;
        bit stable;
        logic [31:0] d;
        do_write(0, 32'h10, 3'd2, 32'hDEADBEEF, lows);
        checks++;
        if (lows !== 0) begin errors++; $display("FAIL zw_write_lows got %0d exp 0", lows); end
        do_read(0, 32'h10, d, lows, stable);
        checks++;
        if (lows !== 0) begin errors++; $display("FAIL zw_read_lows got %0d exp 0", lows); end
        checks++;
        if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_read_data got %h exp DEADBEEF", d); end
    endtask

    task automatic test_back_to_back();
        int lows;
        bit stable;
        logic wr_rdy, rd_rdy;
        logic [31:0] d;
        do_write(0, 32'h10, 3'd2, 32'h11223344, lows);
        do_write(0, 32'h14, 3'd2, 32'h55667788, lows);
        // Byte 0xAA into lane 3 of word 0x10 with the read right behind it.
        pipe_wr_rd(32'h13, 3'd0, 32'hAA000000, 32'h10, wr_rdy, rd_rdy, d);
        checks++;
        if (wr_rdy !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready got %b exp 1", wr_rdy); end
        checks++;
        if (rd_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready got %b exp 1", rd_rdy); end
        checks++;
        if (d !== 32'hAA223344) begin errors++; $display("FAIL b2b_bypass_data got %h exp AA223344", d); end
        do_read(0, 32'h10, d, lows, stable);
        checks++;
        if (d !== 32'hAA223344) begin errors++; $display("FAIL b2b_mem_after_byte got %h exp AA223344", d); end
        // Half into lanes 2,3 of 0x10, read of a different word behind it.
        pipe_wr_rd(32'h12, 3'd1, 32'hBEEF0000, 32'h14, wr_rdy, rd_rdy, d);
        checks++;
        if (d !== 32'h55667788) begin errors++; $display("FAIL b2b_no_bypass_other_word got %h exp 55667788", d); end
        do_read(0, 32'h10, d, lows, stable);
        checks++;
        if (d !== 32'hBEEF3344) begin errors++; $display("FAIL half_upper_lanes got %h exp BEEF3344", d); end
        do_write(0, 32'h11, 3'd0, 32'h00005A00, lows);
        do_read(0, 32'h10, d, lows, stable);
        checks++;
        if (d !== 32'hBEEF5A44) begin errors++; $display("FAIL byte_lane1 got %h exp BEEF5A44", d); end
    endtask

    task automatic test_wait_states();
        int lows;
        bit stable;
        logic [31:0] d;
        do_write(1, 32'h20, 3'd2, 32'hCAFEF00D, lows);
        checks++;
        if (lows !== 2) begin errors++; $display("FAIL ws2_write_lows got %0d exp 2", lows); end
        do_read(1, 32'h20, d, lows, stable);
        checks++;
        if (lows !== 2) begin errors++; $display("FAIL ws2_read_lows got %0d exp 2", lows); end
        checks++;
        if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL ws2_read_data got %h exp CAFEF00D", d); end
        checks++;
        if (stable !== 1'b1) begin errors++; $display("FAIL ws2_rdata_stable got %b exp 1", stable); end
    endtask

    task automatic test_error();
        int lows;
        bit stable;
        logic [31:0] d;
        logic [1:0] rr_exp [3];
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b11; rr_exp[2] = 2'b10;   // {HREADYOUT,HRESP}
        // Misaligned half write on u0 must error and leave memory untouched.
        do_write(0, 32'h00, 3'd2, 32'h01020304, lows);
        addr_phase(0, 32'h01, 1'b1, 3'd1);
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge HCLK);
            checks++;
            if ({hro[0], hrs[0]} !== rr_exp[c]) begin
                errors++;
                $display("FAIL err_half_cycle%0d got ready/resp %b exp %b", c, {hro[0], hrs[0]}, rr_exp[c]);
            end
        end
        @(posedge HCLK); #1;
        $display("error half write u0 addr=00000001 done");
        do_read(0, 32'h00, d, lows, stable);
        checks++;
        if (d !== 32'h01020304) begin errors++; $display("FAIL err_mem_unchanged got %h exp 01020304", d); end
        // HSIZE=3 read on u2 (3 wait states): ERROR with no wait cycles, HRDATA 0.
        do_write(2, 32'h00, 3'd2, 32'h77777777, lows);
        do_read(2, 32'h00, d, lows, stable);
        checks++;
        if (d !== 32'h77777777) begin errors++; $display("FAIL ws3_read_data got %h exp 77777777", d); end
        addr_phase(2, 32'h00, 1'b0, 3'd3);
        @(posedge HCLK); #1;
        bus_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge HCLK);
            checks++;
            if ({hro[2], hrs[2]} !== rr_exp[c]) begin
                errors++;
                $display("FAIL err_size3_cycle%0d got ready/resp %b exp %b", c, {hro[2], hrs[2]}, rr_exp[c]);
            end
            if (c < 2) begin
                checks++;
                if (hrd[2] !== 32'd0) begin errors++; $display("FAIL err_size3_hrdata%0d got %h exp 00000000", c, hrd[2]); end
            end
        end
        @(posedge HCLK); #1;
        $display("error size3 read u2 done");
    endtask

    task automatic test_reset_mid();
        int lows;
        bit stable;
        logic [31:0] d;
        do_write(2, 32'h40, 3'd2, 32'h0BADF00D, lows);
        checks++;
        if (lows !== 3) begin errors++; $display("FAIL ws3_write_lows got %0d exp 3", lows); end
        do_read(2, 32'h40, d, lows, stable);
        addr_phase(2, 32'h40, 1'b1, 3'd2);
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = 32'hFFFFFFFF;
        @(negedge HCLK);
        checks++;
        if (hro[2] !== 1'b0) begin errors++; $display("FAIL rstmid_in_wait got %b exp 0", hro[2]); end
        #2 HRESETn = 1'b0;
        #1;
        checks++;
        if (hro[2] !== 1'b1) begin errors++; $display("FAIL rstmid_hreadyout got %b exp 1", hro[2]); end
        checks++;
        if (hrs[2] !== 1'b0) begin errors++; $display("FAIL rstmid_hresp got %b exp 0", hrs[2]); end
        checks++;
        if (hrd[2] !== 32'd0) begin errors++; $display("FAIL rstmid_hrdata got %h exp 00000000", hrd[2]); end
        @(posedge HCLK);
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        $display("reset during wait of write u2 addr=00000040");
        do_read(2, 32'h40, d, lows, stable);
        checks++;
        if (d !== 32'h0BADF00D) begin errors++; $display("FAIL rstmid_write_dropped got %h exp 0BADF00D", d); end
    endtask

    initial begin
        HRESETn = 1'b0;
        HWDATA  = 32'd0;
        bus_idle();
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        test_reset();
        test_zero_wait();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
